tetron_collision_checker: RTL and testbench

// - Consumes the four block offsets from a tetron shaper and the piece origin.
// - Resolves each block to an absolute playfield cell.
// - Probes the playfield RAM one cell per cycle.
// - Reports whether the piece collides with a wall, the floor or an occupied cell.
// - Sits between the game controller (move/rotate legality) and the playfield RAM read port.

---
 rtl/tetron_collision_checker_if.sv | 72 +++++++
 rtl/tetron_collision_checker.sv | 176 +++++++++++++++++
 tb/tb_tetron_collision_checker.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tetron_collision_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tetron_collision_checker_if                                     |
// | Purpose  : Bundles the request, playfield read port and result signals of  |
// |            the tetron collision checker.                                   |
// | Ports    : start, origin_v/h, blkN_voffset/hoffset (request)               |
// |            rd_en, rd_addr, rd_data (playfield read port)                   |
// |            busy, done, collide (status/result)                             |
// |            lock_start, lock_colour, wr_en, wr_addr, wr_data (lock mode,    |
// |            present only with TETRON_LOCK_WRITE_EN defined)                 |
// | Modports : master = controller/RAM side, slave = checker side             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface tetron_collision_checker_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [4:0]        origin_v;
  logic [4:0]        origin_h;
  logic [4:0]        blk1_voffset;
  logic [4:0]        blk1_hoffset;
  logic [4:0]        blk2_voffset;
  logic [4:0]        blk2_hoffset;
  logic [4:0]        blk3_voffset;
  logic [4:0]        blk3_hoffset;
  logic [4:0]        blk4_voffset;
  logic [4:0]        blk4_hoffset;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data;
  logic              busy;
  logic              done;
  logic              collide;
`ifdef TETRON_LOCK_WRITE_EN
  logic              lock_start;
  logic [2:0]        lock_colour;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_data;

  modport master (
    output start, origin_v, origin_h,
    output blk1_voffset, blk1_hoffset, blk2_voffset, blk2_hoffset,
    output blk3_voffset, blk3_hoffset, blk4_voffset, blk4_hoffset,
    output rd_data, lock_start, lock_colour,
    input  rd_en, rd_addr, busy, done, collide, wr_en, wr_addr, wr_data
  );
  modport slave (
    input  start, origin_v, origin_h,
    input  blk1_voffset, blk1_hoffset, blk2_voffset, blk2_hoffset,
    input  blk3_voffset, blk3_hoffset, blk4_voffset, blk4_hoffset,
    input  rd_data, lock_start, lock_colour,
    output rd_en, rd_addr, busy, done, collide, wr_en, wr_addr, wr_data
  );
`else
  modport master (
    output start, origin_v, origin_h,
    output blk1_voffset, blk1_hoffset, blk2_voffset, blk2_hoffset,
    output blk3_voffset, blk3_hoffset, blk4_voffset, blk4_hoffset,
    output rd_data,
    input  rd_en, rd_addr, busy, done, collide
  );
  modport slave (
    input  start, origin_v, origin_h,
    input  blk1_voffset, blk1_hoffset, blk2_voffset, blk2_hoffset,
    input  blk3_voffset, blk3_hoffset, blk4_voffset, blk4_hoffset,
    input  rd_data,
    output rd_en, rd_addr, busy, done, collide
  );
`endif
endinterface
`default_nettype wire

// File: rtl/tetron_collision_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tetron_collision_checker                                        |
// | Purpose  : Resolves the four blocks of a tetron to playfield cells, probes  |
// |            the playfield RAM one cell per cycle and reports collision with |
// |            walls, floor or occupied cells. Fixed 6-cycle latency.          |
// | Ports    : clk, reset (sync, active-high), bus (slave modport of           |
// |            tetron_collision_checker_if)                                    |
// | Config   : TETRON_LOCK_WRITE_EN adds a lock mode that stamps the piece     |
// |            into the playfield through the write port.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tetron_collision_checker #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int ADDR_W  = 8
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  tetron_collision_checker_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PROBE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic signed [6:0] C_BOARD_W = 7'(BOARD_W);
  localparam logic signed [6:0] C_BOARD_H = 7'(BOARD_H);

  logic [1:0]        r_state;
  logic [1:0]        r_idx;
  logic [4:0]        r_origin_v;
  logic [4:0]        r_origin_h;
  logic [4:0]        r_voff [4];
  logic [4:0]        r_hoff [4];
  logic              r_pend;      // a read was issued last cycle
  logic              r_acc;       // sticky collision accumulator
  logic              r_collide;
  logic [ADDR_W-1:0] r_rd_addr;

  logic              w_lock;
  logic              w_go;
  logic              w_accept;
  logic              w_probe;
  logic [4:0]        w_voff;
  logic [4:0]        w_hoff;
  logic signed [6:0] w_row;
  logic signed [6:0] w_col;
  logic              w_oob;
  logic              w_in;
  logic [ADDR_W-1:0] w_addr;
  logic              w_rd;

  // Block currently being probed
  assign w_voff  = r_voff[r_idx];
  assign w_hoff  = r_hoff[r_idx];
  assign w_row   = $signed({2'b00, r_origin_v}) + $signed({{2{w_voff[4]}}, w_voff});
  assign w_col   = $signed({2'b00, r_origin_h}) + $signed({{2{w_hoff[4]}}, w_hoff});

  // Negative rows are the spawn area and only count as free when the column is legal
  assign w_oob   = w_col[6] || (w_col >= C_BOARD_W) || (w_row >= C_BOARD_H);
  assign w_in    = !w_oob && !w_row[6];
  assign w_addr  = ADDR_W'(w_row[5:0]) * ADDR_W'(BOARD_W) + ADDR_W'(w_col[5:0]);

  assign w_probe  = (r_state == ST_PROBE);
  assign w_accept = (r_state == ST_IDLE) && w_go;
  assign w_rd     = w_probe && w_in && !w_lock;

  assign bus.rd_en   = w_rd;
  assign bus.rd_addr = w_rd ? w_addr : r_rd_addr;
  assign bus.busy    = (r_state == ST_PROBE) || (r_state == ST_DRAIN);
  assign bus.done    = (r_state == ST_DONE);
  assign bus.collide = r_collide;

`ifdef TETRON_LOCK_WRITE_EN
  logic              r_lock;
  logic [2:0]        r_colour;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [2:0]        r_wr_data;
  logic              w_wr;

  assign w_go         = bus.start || bus.lock_start;
  assign w_lock       = r_lock;
  assign w_wr         = w_probe && w_in && r_lock;
  assign bus.wr_en    = w_wr;
  assign bus.wr_addr  = w_wr ? w_addr : r_wr_addr;
  assign bus.wr_data  = w_wr ? r_colour : r_wr_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock    <= 1'b0;
      r_colour  <= 3'd0;
      r_wr_addr <= '0;
      r_wr_data <= 3'd0;
    end else begin
      if (w_accept) begin
        // A plain check request takes priority over a lock request
        r_lock   <= !bus.start;
        r_colour <= bus.lock_colour;
      end
      if (w_wr) begin
        r_wr_addr <= w_addr;
        r_wr_data <= r_colour;
      end
    end
  end
`else
  assign w_go   = bus.start;
  assign w_lock = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= 2'd0;
      r_origin_v <= 5'd0;
      r_origin_h <= 5'd0;
      for (int i = 0; i < 4; i++) begin
        r_voff[i] <= 5'd0;
        r_hoff[i] <= 5'd0;
      end
      r_pend     <= 1'b0;
      r_acc      <= 1'b0;
      r_collide  <= 1'b0;
      r_rd_addr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state    <= ST_PROBE;
            r_idx      <= 2'd0;
            r_origin_v <= bus.origin_v;
            r_origin_h <= bus.origin_h;
            r_voff[0]  <= bus.blk1_voffset;
            r_hoff[0]  <= bus.blk1_hoffset;
            r_voff[1]  <= bus.blk2_voffset;
            r_hoff[1]  <= bus.blk2_hoffset;
            r_voff[2]  <= bus.blk3_voffset;
            r_hoff[2]  <= bus.blk3_hoffset;
            r_voff[3]  <= bus.blk4_voffset;
            r_hoff[3]  <= bus.blk4_hoffset;
            r_pend     <= 1'b0;
            r_acc      <= 1'b0;
            r_collide  <= 1'b0;
          end
        end
        ST_PROBE: begin
          // Fold in this block's bounds verdict and last cycle's RAM answer
          r_acc  <= r_acc | (w_oob & !w_lock) | (r_pend & bus.rd_data);
          r_pend <= w_rd;
          r_idx  <= r_idx + 2'd1;
          if (w_rd) begin
            r_rd_addr <= w_addr;
          end
          if (r_idx == 2'd3) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_collide <= w_lock ? 1'b0 : (r_acc | (r_pend & bus.rd_data));
          r_pend    <= 1'b0;
          r_state   <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tetron_collision_checker.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_tetron_collision_checker                                     |
// | Purpose  : Self-checking bench for tetron_collision_checker: directed      |
// |            vector table, hand-written corner sequences and randomized      |
// |            checks against a cell-classification reference model.          |
// | Config   : exercises lock mode when TETRON_LOCK_WRITE_EN is defined.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_tetron_collision_checker;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tetron_collision_checker_if #(.ADDR_W(8)) bus ();

  tetron_collision_checker #(
    .BOARD_W(10),
    .BOARD_H(20),
    .ADDR_W (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Playfield RAM: 1-cycle read latency, junk on the data line when not read
  bit mem [0:255];
  always @(posedge clk) bus.rd_data <= bus.rd_en ? mem[bus.rd_addr] : 1'($urandom);

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    int              ov;
    int              oh;
    logic [3:0][4:0] vo;
    logic [3:0][4:0] ho;
    int              occ;
    int              exp_col;
    int              exp_n;
    int              exp_addr [4];
  } vec_t;

  function automatic vec_t mk(input int ov, oh,
                              input int v1, h1, v2, h2, v3, h3, v4, h4,
                              input int occ, col, n, a1, a2, a3, a4);
    vec_t v;
    v.ov = ov; v.oh = oh;
    v.vo[0] = 5'(v1); v.ho[0] = 5'(h1);
    v.vo[1] = 5'(v2); v.ho[1] = 5'(h2);
    v.vo[2] = 5'(v3); v.ho[2] = 5'(h3);
    v.vo[3] = 5'(v4); v.ho[3] = 5'(h4);
    v.occ = occ; v.exp_col = col; v.exp_n = n;
    v.exp_addr[0] = a1; v.exp_addr[1] = a2; v.exp_addr[2] = a3; v.exp_addr[3] = a4;
    return v;
  endfunction

  // Reference model: classify each block cell from the game rules
  int exp_q [$];
  int exp_col;

  task automatic model(input int ov, oh, input logic [3:0][4:0] vo, ho, input bit lock);
    exp_q.delete();
    exp_col = 0;
    for (int b = 0; b < 4; b++) begin
      int r, c;
      r = ov + int'($signed(vo[b]));
      c = oh + int'($signed(ho[b]));
      if (c < 0 || c >= 10 || r >= 20) begin
        if (!lock) exp_col = 1;
      end else if (r >= 0) begin
        exp_q.push_back(r * 10 + c);
        if (!lock && mem[r * 10 + c]) exp_col = 1;
      end
    end
  endtask

  // Observations of one operation
  int obs_q [$];
  int done_cyc, busy_err, stray, wd_err, obs_col, post_busy, post_done, hold_addr;

  task automatic drive_inputs(input int ov, oh, input logic [3:0][4:0] vo, ho);
    bus.origin_v = 5'(ov);    bus.origin_h = 5'(oh);
    bus.blk1_voffset = vo[0]; bus.blk1_hoffset = ho[0];
    bus.blk2_voffset = vo[1]; bus.blk2_hoffset = ho[1];
    bus.blk3_voffset = vo[2]; bus.blk3_hoffset = ho[2];
    bus.blk4_voffset = vo[3]; bus.blk4_hoffset = ho[3];
  endtask

  task automatic scramble();
    logic [3:0][4:0] rv, rh;
    rv = 20'($urandom); rh = 20'($urandom);
    drive_inputs(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), rv, rh);
  endtask

  // Cycle 0 = edge that samples the request; samples taken at negedges of cycles 1..7
  task automatic run_op(input int ov, oh, input logic [3:0][4:0] vo, ho,
                        input bit lock, input logic [2:0] colour,
                        input bit repulse, input bit b2b);
    if (!b2b) @(negedge clk);
    drive_inputs(ov, oh, vo, ho);
`ifdef TETRON_LOCK_WRITE_EN
    bus.lock_colour = colour;
    if (lock) bus.lock_start = 1'b1;
    else      bus.start      = 1'b1;
`else
    bus.start = 1'b1;
`endif
    @(negedge clk);
    bus.start = 1'b0;
`ifdef TETRON_LOCK_WRITE_EN
    bus.lock_start  = 1'b0;
    bus.lock_colour = 3'($urandom);
`endif
    scramble();
    obs_q.delete();
    done_cyc = 0; busy_err = 0; stray = 0; wd_err = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.rd_en) begin
        if (lock) stray++;
        else obs_q.push_back(int'(bus.rd_addr));
      end
`ifdef TETRON_LOCK_WRITE_EN
      if (bus.wr_en) begin
        if (!lock) stray++;
        else begin
          obs_q.push_back(int'(bus.wr_addr));
          if (bus.wr_data != colour) wd_err++;
        end
      end
`endif
      if (bus.done && done_cyc == 0) done_cyc = c;
      if (bus.busy != (c <= 5)) busy_err++;
      if (repulse) begin
        if (c == 2) begin bus.start = 1'b1; scramble(); end
        if (c == 3) bus.start = 1'b0;
        if (c == 6) bus.start = 1'b1;
      end
    end
    obs_col = int'(bus.collide);
    @(negedge clk);
    bus.start = 1'b0;
    post_busy = int'(bus.busy);
    post_done = int'(bus.done);
    hold_addr = int'(bus.rd_addr);
  endtask

  task automatic check_common(input string tag);
    chk({tag, " done_cycle"}, done_cyc, 6);
    chk({tag, " busy_shape"}, busy_err, 0);
    chk({tag, " stray_strobe"}, stray, 0);
    chk({tag, " idle_after"}, post_busy + post_done, 0);
  endtask

  vec_t vecs [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
`ifdef TETRON_LOCK_WRITE_EN
    bus.lock_start  = 1'b0;
    bus.lock_colour = 3'd0;
`endif
    drive_inputs(0, 0, '0, '0);
    for (int i = 0; i < 256; i++) mem[i] = 1'b0;

    vecs[0] = mk(5, 4,  0, 0, -1, 0,  0,-1,  1,-1,  -1, 0, 4,  54, 44, 53, 63);
    vecs[1] = mk(5, 4,  0, 0, -1, 0,  0,-1,  1,-1,  63, 1, 4,  54, 44, 53, 63);
    vecs[2] = mk(5, 0,  0, 0, -1, 0,  0,-1,  1, 0,  -1, 1, 3,  50, 40, 60,  0);
    vecs[3] = mk(0, 4,  0, 0, -1, 0,  0, 1,  1, 0,  -1, 0, 3,   4,  5, 14,  0);
    vecs[4] = mk(19,4,  0, 0,  1, 0,  0, 1,  0,-1,  -1, 1, 3, 194,195,193,  0);
    vecs[5] = mk(0, 9,  0, 0,  0, 1,  1, 0,  2, 0,  -1, 1, 3,   9, 19, 29,  0);
    vecs[6] = mk(0, 0, -1,-1, -1, 0,  0, 0,  0, 1,  -1, 1, 2,   0,  1,  0,  0);
    vecs[7] = mk(3, 3,  0, 0,  0, 1,  1, 0,  1, 1,  44, 1, 4,  33, 34, 43, 44);
    vecs[8] = mk(3, 3,  0, 0,  0, 1,  1, 0,  1, 1,  33, 1, 4,  33, 34, 43, 44);
    vecs[9] = mk(5, 4,  0, 0, -1, 0,  0,-1,  1,-1,  55, 0, 4,  54, 44, 53, 63);

    repeat (3) @(negedge clk);
    chk("reset rd_en", int'(bus.rd_en), 0);
    chk("reset rd_addr", int'(bus.rd_addr), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset collide", int'(bus.collide), 0);
`ifdef TETRON_LOCK_WRITE_EN
    chk("reset wr_en", int'(bus.wr_en), 0);
    chk("reset wr_addr", int'(bus.wr_addr), 0);
    chk("reset wr_data", int'(bus.wr_data), 0);
`endif
    reset = 1'b0;

    // Directed vector table
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = 1'b0;
      if (vecs[t].occ >= 0) mem[vecs[t].occ] = 1'b1;
      run_op(vecs[t].ov, vecs[t].oh, vecs[t].vo, vecs[t].ho, 1'b0, 3'd0, 1'b0, 1'b0);
      check_common($sformatf("vec%0d", t));
      chk($sformatf("vec%0d n_reads", t), obs_q.size(), vecs[t].exp_n);
      for (int i = 0; i < vecs[t].exp_n && i < obs_q.size(); i++)
        chk($sformatf("vec%0d addr%0d", t, i), obs_q[i], vecs[t].exp_addr[i]);
      chk($sformatf("vec%0d collide", t), obs_col, vecs[t].exp_col);
      chk($sformatf("vec%0d addr_hold", t), hold_addr, vecs[t].exp_addr[vecs[t].exp_n - 1]);
    end

    // start re-pulsed on cycles 2 and 6 must be ignored
    for (int i = 0; i < 256; i++) mem[i] = 1'b0;
    mem[63] = 1'b1;
    run_op(5, 4, vecs[0].vo, vecs[0].ho, 1'b0, 3'd0, 1'b1, 1'b0);
    check_common("repulse");
    chk("repulse n_reads", obs_q.size(), 4);
    chk("repulse collide", obs_col, 1);

    // start on cycle 7 is accepted back-to-back
    mem[63] = 1'b0;
    run_op(5, 4, vecs[0].vo, vecs[0].ho, 1'b0, 3'd0, 1'b0, 1'b1);
    check_common("b2b");
    chk("b2b n_reads", obs_q.size(), 4);
    chk("b2b collide", obs_col, 0);

    // Reset on cycle 3 aborts without a done pulse
    mem[63] = 1'b1;
    run_op(5, 4, vecs[0].vo, vecs[0].ho, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("pre_abort collide", obs_col, 1);
    @(negedge clk);
    drive_inputs(5, 4, vecs[0].vo, vecs[0].ho);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort busy", int'(bus.busy), 0);
    chk("abort done", int'(bus.done), 0);
    chk("abort rd_en", int'(bus.rd_en), 0);
    chk("abort rd_addr", int'(bus.rd_addr), 0);
    chk("abort collide", int'(bus.collide), 0);
    reset = 1'b0;
    begin
      int dones = 0;
      repeat (6) begin
        @(negedge clk);
        if (bus.done || bus.busy) dones++;
      end
      chk("abort no_done", dones, 0);
    end

`ifdef TETRON_LOCK_WRITE_EN
    // Lock: stamp colour 5 at origin (5,4)
    for (int i = 0; i < 256; i++) mem[i] = 1'b1;
    run_op(5, 4, vecs[0].vo, vecs[0].ho, 1'b1, 3'd5, 1'b0, 1'b0);
    check_common("lock");
    chk("lock n_writes", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++)
      chk($sformatf("lock addr%0d", i), obs_q[i], vecs[0].exp_addr[i]);
    chk("lock wr_data", wd_err, 0);
    chk("lock collide", obs_col, 0);
`endif

    // Randomized checks against the reference model
    for (int it = 0; it < 200; it++) begin
      int ov, oh;
      logic [3:0][4:0] vo, ho;
      bit lock;
      logic [2:0] colour;
      for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 3) == 0);
      ov = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 22));
      oh = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 11));
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) begin
          vo[b] = 5'($urandom);
          ho[b] = 5'($urandom);
        end else begin
          vo[b] = 5'(int'($urandom_range(0, 6)) - 3);
          ho[b] = 5'(int'($urandom_range(0, 6)) - 3);
        end
      end
`ifdef TETRON_LOCK_WRITE_EN
      lock = ($urandom_range(0, 3) == 0);
`else
      lock = 1'b0;
`endif
      colour = 3'($urandom);
      model(ov, oh, vo, ho, lock);
      run_op(ov, oh, vo, ho, lock, colour, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
      check_common($sformatf("rand%0d", it));
      chk($sformatf("rand%0d n_access", it), obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
        chk($sformatf("rand%0d addr%0d", it, i), obs_q[i], exp_q[i]);
      chk($sformatf("rand%0d collide", it), obs_col, exp_col);
      chk($sformatf("rand%0d wr_data", it), wd_err, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
